// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared widths and enums for the IF/DM memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (IF/DM) arbiter onto one memory port, one outstanding
//            transaction, DM priority with bounded IF starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import core_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DW/8-1:0]   dm_be,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DW-1:0]     dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic              err_spurious
);

  localparam int c_cw = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_cw-1:0] c_max_wait = c_cw'(MAX_WAIT);

  state_t              r_state;
  owner_t              r_owner;
  logic [c_cw-1:0]     r_starve;
  logic                r_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [DW/8-1:0]     r_mem_be;
  logic [AW-1:0]       r_mem_addr;
  logic [DW-1:0]       r_mem_wdata;

  logic w_any_req;
  logic w_arb;
  logic w_pick_if;
  logic w_gnt;
  logic w_rsp;

  assign w_any_req = if_req | dm_req;
  assign w_arb     = w_any_req & ((r_state == IDLE) | ((r_state == RESP) & mem_rvalid));
  // IF only overtakes a competing DM request once it has been passed over MAX_WAIT times
  assign w_pick_if = if_req & (~dm_req | (r_starve == c_max_wait));
  assign w_gnt     = (r_state == REQ) & mem_gnt;
  assign w_rsp     = (r_state == RESP) & mem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_DM;
      r_starve    <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (mem_rvalid && (r_state != RESP))
        r_err <= 1'b1;

      if (!if_req)
        r_starve <= '0;
      else if (w_gnt) begin
        if (r_owner == OWN_IF)
          r_starve <= '0;
        else if (r_starve != c_max_wait)
          r_starve <= r_starve + 1'b1;
      end

      case (r_state)
        REQ: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= RESP;
        end
        RESP: if (mem_rvalid && !w_any_req)
          r_state <= IDLE;
        default: r_state <= r_state;
      endcase

      // A new arbitration overrides the plain state transitions above
      if (w_arb) begin
        r_state   <= REQ;
        r_mem_req <= 1'b1;
        if (w_pick_if) begin
          r_owner     <= OWN_IF;
          r_mem_we    <= 1'b0;
          r_mem_be    <= '1;
          r_mem_addr  <= if_addr;
          r_mem_wdata <= '0;
        end else begin
          r_owner     <= OWN_DM;
          r_mem_we    <= dm_we;
          r_mem_be    <= dm_be;
          r_mem_addr  <= dm_addr;
          r_mem_wdata <= dm_wdata;
        end
      end
    end
  end

  assign if_gnt       = w_gnt & (r_owner == OWN_IF);
  assign dm_gnt       = w_gnt & (r_owner == OWN_DM);
  assign if_rvalid    = w_rsp & (r_owner == OWN_IF);
  assign dm_rvalid    = w_rsp & (r_owner == OWN_DM);
  assign if_rdata     = if_rvalid ? mem_rdata : '0;
  assign dm_rdata     = dm_rvalid ? mem_rdata : '0;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_be       = r_mem_be;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign busy         = (r_state != IDLE);
  assign err_spurious = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: transaction-level model,
//            directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [BW-1:0] dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy, err_spurious;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err_spurious(err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one memory transaction in flight
  typedef struct {
    bit            valid;
    bit            granted;
    bit            own_if;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t m_txn = '{default: 0};
  int   m_starve = 0;
  bit   m_err = 1'b0;
  bit   chk_on = 1'b0;
  bit   glog[$];

  always @(posedge clk or posedge rst) begin : model
    bit arb, pick_if;
    if (rst) begin
      m_txn.valid = 0; m_txn.granted = 0; m_starve = 0; m_err = 0;
    end else begin
      if (mem_rvalid && !(m_txn.valid && m_txn.granted)) m_err = 1;
      arb     = (if_req || dm_req) && (!m_txn.valid || (m_txn.granted && mem_rvalid));
      pick_if = if_req && (!dm_req || m_starve == MAX_WAIT);
      if (m_txn.valid && !m_txn.granted && mem_gnt) begin
        m_txn.granted = 1;
        if (m_txn.own_if) m_starve = 0;
        else if (if_req && m_starve < MAX_WAIT) m_starve++;
      end else if (m_txn.valid && m_txn.granted && mem_rvalid) begin
        m_txn.valid = 0;
      end
      if (!if_req) m_starve = 0;
      if (arb) begin
        m_txn.valid = 1; m_txn.granted = 0; m_txn.own_if = pick_if;
        if (pick_if) begin
          m_txn.we = 0; m_txn.be = '1; m_txn.addr = if_addr; m_txn.wdata = '0;
        end else begin
          m_txn.we = dm_we; m_txn.be = dm_be; m_txn.addr = dm_addr; m_txn.wdata = dm_wdata;
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin : cmp
    bit e_req, e_ifg, e_dmg, e_ifv, e_dmv;
    e_req = m_txn.valid && !m_txn.granted;
    e_ifg = e_req && m_txn.own_if && mem_gnt;
    e_dmg = e_req && !m_txn.own_if && mem_gnt;
    e_ifv = m_txn.valid && m_txn.granted && m_txn.own_if && mem_rvalid;
    e_dmv = m_txn.valid && m_txn.granted && !m_txn.own_if && mem_rvalid;
    check("mem_req", mem_req, e_req);
    check("if_gnt", if_gnt, e_ifg);
    check("dm_gnt", dm_gnt, e_dmg);
    check("if_rvalid", if_rvalid, e_ifv);
    check("dm_rvalid", dm_rvalid, e_dmv);
    check("if_rdata", if_rdata, e_ifv ? mem_rdata : '0);
    check("dm_rdata", dm_rdata, e_dmv ? mem_rdata : '0);
    check("busy", busy, m_txn.valid);
    check("err_spurious", err_spurious, m_err);
    if (e_req) begin
      check("mem_we", mem_we, m_txn.we);
      check("mem_be", mem_be, m_txn.be);
      check("mem_addr", mem_addr, m_txn.addr);
      check("mem_wdata", mem_wdata, m_txn.wdata);
    end
    if (if_gnt) glog.push_back(1'b1);
    if (dm_gnt) glog.push_back(1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Randomized requesters and memory; requests hold until granted, then drain.
  task automatic run_random(input int n, input int preq, input int pgnt, input int prv);
    int k;
    bit if_g, dm_g, acc, rsp_pend, new_ok;
    k = 0; if_g = 0; dm_g = 0; acc = 0; rsp_pend = 0;
    forever begin
      new_ok = (k < n);
      if (!new_ok && !busy && !if_req && !dm_req && !rsp_pend && !acc) break;
      if (k >= n + 300) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: still busy=%0b after %0d cycles, expected idle", busy, k);
        break;
      end
      tick();
      if (acc) rsp_pend = 1;
      if (if_req && if_g) if_req = 0;
      if (!if_req && new_ok && $urandom_range(99) < preq) begin
        if_req = 1; if_addr = $urandom & ~32'h3;
      end
      if (dm_req && dm_g) dm_req = 0;
      if (!dm_req && new_ok && $urandom_range(99) < preq) begin
        dm_req = 1; dm_we = 1'($urandom_range(1)); dm_be = 4'($urandom_range(15, 1));
        dm_addr = $urandom & ~32'h3; dm_wdata = $urandom;
      end
      mem_gnt = mem_req && ($urandom_range(99) < pgnt);
      if (rsp_pend && $urandom_range(99) < prv) begin
        mem_rvalid = 1; rsp_pend = 0;
      end else begin
        mem_rvalid = 0;
      end
      mem_rdata = $urandom;
      @(negedge clk);
      if_g = if_gnt; dm_g = dm_gnt; acc = mem_req && mem_gnt;
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle_inputs();
    chk_on = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_spurious, 0);
    tick(); rst = 0;

    // IF-only read
    tick(); if_req = 1; if_addr = 32'h0000_0040;
    @(negedge clk); check("t1_idle_busy", busy, 0);
    tick(); mem_gnt = 1;
    @(negedge clk);
    check("t1_mem_req", mem_req, 1); check("t1_if_gnt", if_gnt, 1);
    check("t1_mem_addr", mem_addr, 32'h40); check("t1_mem_be", mem_be, 4'hF);
    check("t1_mem_we", mem_we, 0);
    tick(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2402_0005;
    @(negedge clk);
    check("t1_if_rvalid", if_rvalid, 1); check("t1_if_rdata", if_rdata, 32'h2402_0005);
    tick(); mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t1_busy_end", busy, 0); check("t1_if_rdata_zero", if_rdata, 0);

    // Simultaneous IF and DM write: DM first, IF back-to-back
    tick(); if_req = 1; if_addr = 32'h44;
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick(); mem_gnt = 1;
    @(negedge clk);
    check("t2_dm_gnt", dm_gnt, 1); check("t2_if_gnt", if_gnt, 0);
    check("t2_mem_we", mem_we, 1); check("t2_mem_addr", mem_addr, 32'h100);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    @(negedge clk); check("t2_dm_rvalid", dm_rvalid, 1); check("t2_if_rvalid", if_rvalid, 0);
    tick(); mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    check("t2_b2b_if_gnt", if_gnt, 1); check("t2_b2b_addr", mem_addr, 32'h44);
    check("t2_b2b_we", mem_we, 0);
    tick(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); check("t2_if_rdata", if_rdata, 32'h1234_5678);
    tick(); mem_rvalid = 0;

    // Byte write
    tick(); dm_req = 1; dm_we = 1; dm_be = 4'h2; dm_addr = 32'h300; dm_wdata = 32'h0000_AB00;
    tick(); mem_gnt = 1;
    @(negedge clk); check("t3_mem_be", mem_be, 4'h2); check("t3_dm_gnt", dm_gnt, 1);
    tick(); dm_req = 0; mem_gnt = 0;
    @(negedge clk); check("t3_dm_rvalid_wait", dm_rvalid, 0);
    tick(); mem_rvalid = 1;
    @(negedge clk); check("t3_dm_rvalid", dm_rvalid, 1); check("t3_if_rvalid", if_rvalid, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk); check("t3_dm_rvalid_pulse", dm_rvalid, 0); check("t3_busy", busy, 0);

    // Grant withheld 5 cycles; payload changes after latching are ignored
    tick(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      tick(); dm_wdata = $urandom;
      @(negedge clk);
      check("t4_mem_req_hold", mem_req, 1); check("t4_addr_hold", mem_addr, 32'h200);
      check("t4_wdata_hold", mem_wdata, 32'h55); check("t4_no_gnt", dm_gnt, 0);
    end
    tick(); mem_gnt = 1;
    @(negedge clk); check("t4_dm_gnt", dm_gnt, 1);
    tick(); dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk); check("t4_dm_rdata", dm_rdata, 32'h77);
    tick(); mem_rvalid = 0;

    // Starvation bound: continuous requests from both sides
    glog.delete();
    run_random(60, 100, 100, 100);
    if (glog.size() < 10) begin
      n_cmp++; n_bad++;
      $display("FAIL starve_seq_len: got %0d grants, expected at least 10", glog.size());
    end else begin
      for (int i = 0; i < 10; i++) check("starve_seq", glog[i], (i % 5) == 4);
    end

    // Randomized traffic
    run_random(3000, 40, 60, 60);
    run_random(1000, 90, 80, 80);

    // Reset during RESP, then a stray response
    tick(); dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h500;
    tick(); mem_gnt = 1;
    tick(); dm_req = 0; mem_gnt = 0;
    @(negedge clk); check("t5_busy_resp", busy, 1);
    tick(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h99;
    #1;
    check("t5_rst_busy", busy, 0); check("t5_rst_dm_rvalid", dm_rvalid, 0);
    check("t5_rst_mem_req", mem_req, 0); check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_err", err_spurious, 0);
    tick(); rst = 0;
    @(negedge clk); check("t5_err_not_yet", err_spurious, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk); check("t5_err_set", err_spurious, 1); check("t5_no_rvalid", dm_rvalid, 0);
    tick();

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, shall set the address width.
REQ-002 Parameter DW, default 32, shall set the data width.
REQ-003 Parameter MAX_WAIT, default 4, shall set the consecutive DM grants allowed while IF waits.
REQ-004 clk  in  1  shall be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  shall be the asynchronous, active-high reset.
REQ-006 if_req in 1 / if_addr in AW: instruction-fetch read request and address.
REQ-007 if_gnt out 1 / if_rvalid out 1 / if_rdata out DW: IF grant, read-data valid, read data.
REQ-008 dm_req in 1 / dm_we in 1 / dm_be in DW/8 / dm_addr in AW / dm_wdata in DW: data-memory request.
REQ-009 dm_gnt out 1 / dm_rvalid out 1 / dm_rdata out DW: DM grant, response valid, read data.
REQ-010 mem_req out 1 / mem_we out 1 / mem_be out DW/8 / mem_addr out AW / mem_wdata out DW: shared memory port.
REQ-011 mem_gnt in 1 / mem_rvalid in 1 / mem_rdata in DW: memory grant, response valid (reads and writes), read data.
REQ-012 busy out 1: transaction in flight; err_spurious out 1: sticky unexpected mem_rvalid flag.

Function
REQ-013 States: IDLE, REQ, RESP; exactly one memory transaction outstanding.
REQ-014 Arbitration point: IDLE with any request, or RESP on mem_rvalid with any request.
REQ-015 At an arbitration point: latch owner and that requester's payload into registers; next state REQ.
REQ-016 Priority: DM wins when both request, unless starve counter == MAX_WAIT, then IF wins.
REQ-017 Starve counter: +1 per DM grant while if_req high, saturating at MAX_WAIT; cleared on IF grant or if_req low.
REQ-018 REQ: mem_req=1 with latched payload; mem_* outputs registered, stable until mem_gnt.
REQ-019 REQ: owner's x_gnt = mem_gnt, combinational, single-cycle pulse; on mem_gnt go to RESP.
REQ-020 RESP: owner's x_rvalid = mem_rvalid, x_rdata = mem_rdata, combinational; non-owner rvalid stays 0.
REQ-021 RESP with mem_rvalid and no request: go to IDLE; with a request: back-to-back per REQ-014.
REQ-022 Latency: req at IDLE cycle N -> mem_req at N+1; gnt earliest N+1; rvalid earliest N+2.
REQ-023 Requesters shall hold x_req and payload until x_gnt; payload changes after latching are ignored.
REQ-024 IF transactions: mem_we=0, mem_be all ones, mem_wdata 0.
REQ-025 mem_rvalid in IDLE or REQ: dropped, err_spurious set until reset.
REQ-026 busy = (state != IDLE).
REQ-027 if_rdata/dm_rdata shall be 0 whenever the corresponding rvalid is 0.

Reset
REQ-028 rst asserted: state IDLE, starve counter 0, owner DM, err_spurious 0, all mem_* outputs 0, within the same cycle.
REQ-029 Reset mid-transaction: transaction abandoned, no gnt/rvalid to either requester; later mem_rvalid while IDLE sets err_spurious only after reset deasserts.
REQ-030 First arbitration allowed on the first rising clk edge after rst deasserts.

Structure
REQ-031 Shared package core_pkg: AW/DW defaults, state enum (IDLE/REQ/RESP), owner enum (OWN_IF/OWN_DM).
REQ-032 Single module, no sub-modules; starve counter width $clog2(MAX_WAIT+1).

Verification
REQ-033 IF-only read 0x0000_0040, memory gnt same cycle, rvalid next with 0x2402_0005 -> if_gnt at N+1, if_rvalid/if_rdata 0x2402_0005 at N+2, busy low at N+3.
REQ-034 Simultaneous if_req and dm_req (write 0xDEAD_BEEF, be 0xF, addr 0x100) -> DM first with mem_we=1; IF back-to-back on DM rvalid cycle.
REQ-035 dm_req continuous, if_req continuous, MAX_WAIT=4 -> exactly 4 DM grants, then 1 IF grant; pattern repeats.
REQ-036 mem_gnt withheld 5 cycles -> mem_req and payload stable 5 cycles, no x_gnt until mem_gnt.
REQ-037 rst pulsed during RESP -> outputs 0 immediately, no rvalid delivered; stray mem_rvalid after reset sets err_spurious=1.
REQ-038 Byte write dm_be=0x2 -> mem_be=0x2, dm_rvalid single pulse, if_rvalid stays 0.
